// File: rtl/pwm_duty_capture.sv
// Receive side of the PWM link: counts high cycles and rising edges of an
// asynchronous PWM line over back-to-back windows of 2^WIN_LOG2 clocks.
module pwm_duty_capture #(
  parameter int WIN_LOG2    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                pwm_in,
  output logic [WIN_LOG2:0]   duty,
  output logic [7:0]          edges,
  output logic                valid,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALIGN   = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam logic [WIN_LOG2-1:0] CNT_ZERO  = {WIN_LOG2{1'b0}};
  localparam logic [WIN_LOG2-1:0] CNT_ONE   = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] CNT_LAST  = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2:0]   HIGH_ZERO = {(WIN_LOG2+1){1'b0}};

  function automatic logic [7:0] sat_inc8(input logic [7:0] val, input logic inc);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = 8'hFF;
    end else begin
      res = val + {7'd0, inc};
    end
    return res;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;
  logic                   pwm_s;
  logic                   rise_s;

  state_t                 state_q;
  logic [WIN_LOG2-1:0]    win_cnt_q;
  logic [WIN_LOG2-1:0]    tmo_cnt_q;
  logic [WIN_LOG2:0]      high_cnt_q;
  logic [WIN_LOG2:0]      high_cnt_d;
  logic [7:0]             edge_cnt_q;
  logic [7:0]             edge_cnt_d;
  logic [WIN_LOG2:0]      duty_q;
  logic [7:0]             edges_q;
  logic                   valid_q;
  logic                   busy_q;

  assign pwm_s  = sync_q[SYNC_STAGES-1];
  assign rise_s = pwm_s & ~pwm_d_q;

  // Input synchronizer chain plus one extra flop for rising-edge detection
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d_q <= pwm_s;
    end
  end

  // Running totals that include the current cycle's sample
  always_comb begin
    high_cnt_d = high_cnt_q + {{WIN_LOG2{1'b0}}, pwm_s};
    edge_cnt_d = sat_inc8(edge_cnt_q, rise_s);
  end

  // Control FSM with counters and registered result outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      win_cnt_q  <= CNT_ZERO;
      tmo_cnt_q  <= CNT_ZERO;
      high_cnt_q <= HIGH_ZERO;
      edge_cnt_q <= 8'd0;
      duty_q     <= HIGH_ZERO;
      edges_q    <= 8'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          win_cnt_q  <= CNT_ZERO;
          tmo_cnt_q  <= CNT_ZERO;
          high_cnt_q <= HIGH_ZERO;
          edge_cnt_q <= 8'd0;
          busy_q     <= 1'b0;
          if (ena) begin
            state_q <= ST_ALIGN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ALIGN: begin
          // The aligning rise itself is not part of the first window
          if (!ena) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= CNT_ZERO;
            busy_q    <= 1'b0;
          end else if (rise_s || (tmo_cnt_q == CNT_LAST)) begin
            state_q    <= ST_MEASURE;
            tmo_cnt_q  <= CNT_ZERO;
            win_cnt_q  <= CNT_ZERO;
            high_cnt_q <= HIGH_ZERO;
            edge_cnt_q <= 8'd0;
            busy_q     <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
          end
        end
        ST_MEASURE: begin
          if (!ena) begin
            state_q    <= ST_IDLE;
            win_cnt_q  <= CNT_ZERO;
            high_cnt_q <= HIGH_ZERO;
            edge_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
          end else if (win_cnt_q == CNT_LAST) begin
            duty_q     <= high_cnt_d;
            edges_q    <= edge_cnt_d;
            valid_q    <= 1'b1;
            win_cnt_q  <= CNT_ZERO;
            high_cnt_q <= HIGH_ZERO;
            edge_cnt_q <= 8'd0;
          end else begin
            win_cnt_q  <= win_cnt_q + CNT_ONE;
            high_cnt_q <= high_cnt_d;
            edge_cnt_q <= edge_cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign duty  = duty_q;
  assign edges = edges_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Scoreboard bench for pwm_duty_capture: a 32-clock window instance for the
// main scenarios and a 1024-clock window instance for edge saturation.
module tb_pwm_duty_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena_a;
  logic        ena_b;
  logic        pwm_in;
  logic [5:0]  duty_a;
  logic [7:0]  edges_a;
  logic        valid_a;
  logic        busy_a;
  logic [10:0] duty_b;
  logic [7:0]  edges_b;
  logic        valid_b;
  logic        busy_b;

  typedef struct {
    int duty;
    int edges;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   wave_per = 0;
  int   wave_high = 0;
  int   wave_phase = 0;
  logic wave_lvl = 1'b0;
  int   ref_a = 0;
  int   ref_b = 0;
  logic busy_a_prev = 1'b0;
  logic busy_b_prev = 1'b0;

  pwm_duty_capture #(.WIN_LOG2(5), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .pwm_in(pwm_in),
    .duty(duty_a), .edges(edges_a), .valid(valid_a), .busy(busy_a)
  );

  pwm_duty_capture #(.WIN_LOG2(10), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .pwm_in(pwm_in),
    .duty(duty_b), .edges(edges_b), .valid(valid_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // PWM source: constant level when wave_per is 0, else wave_high of wave_per high
  initial begin
    pwm_in = 1'b0;
    forever begin
      @(negedge clk);
      if (wave_per == 0) begin
        pwm_in = wave_lvl;
      end else begin
        if (wave_phase >= wave_per) wave_phase = 0;
        pwm_in = (wave_phase < wave_high);
        wave_phase++;
        if (wave_phase >= wave_per) wave_phase = 0;
      end
    end
  end

  // Output monitors: pop the scoreboard on every valid and check window spacing
  initial forever begin
    @(negedge clk);
    if (busy_a && !busy_a_prev) ref_a = cyc;
    busy_a_prev = busy_a;
    if (valid_a) begin
      check_val("a_sb_nonempty", int'(q_a.size() > 0), 1);
      check_val("a_spacing", cyc - ref_a, 32);
      ref_a = cyc;
      if (q_a.size() > 0) begin
        e_a = q_a.pop_front();
        check_val("a_duty", int'(duty_a), e_a.duty);
        check_val("a_edges", int'(edges_a), e_a.edges);
      end
    end
    if (busy_b && !busy_b_prev) ref_b = cyc;
    busy_b_prev = busy_b;
    if (valid_b) begin
      check_val("b_sb_nonempty", int'(q_b.size() > 0), 1);
      check_val("b_spacing", cyc - ref_b, 1024);
      ref_b = cyc;
      if (q_b.size() > 0) begin
        e_b = q_b.pop_front();
        check_val("b_duty", int'(duty_b), e_b.duty);
        check_val("b_edges", int'(edges_b), e_b.edges);
      end
    end
  end

  task automatic set_wave(input int per, input int hi, input logic lvl);
    ena_a = 1'b0;
    wave_per = per;
    wave_high = hi;
    wave_lvl = lvl;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_busy_a(input string name, output int lat);
    int n;
    int t0;
    t0 = cyc;
    n = 0;
    ena_a = 1'b1;
    while (!busy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val({name, "_busy_rise"}, int'(busy_a), 1);
    lat = cyc - t0;
  endtask

  task automatic drain_a(input string name, input int bound);
    int n;
    n = 0;
    while (q_a.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_val({name, "_drained"}, q_a.size(), 0);
    q_a.delete();
  endtask

  task automatic run_a(input string name, input int per, input int hi, input logic lvl,
                       input int nwin, input int exp_duty, input int exp_edges,
                       input int align_lat);
    exp_t e;
    int   lat;
    set_wave(per, hi, lvl);
    e.duty  = exp_duty;
    e.edges = exp_edges;
    for (int i = 0; i < nwin; i++) q_a.push_back(e);
    wait_busy_a(name, lat);
    if (align_lat >= 0) check_val({name, "_align_lat"}, lat, align_lat);
    drain_a(name, nwin * 32 + 64);
    ena_a = 1'b0;
    @(negedge clk);
    check_val({name, "_busy_fall"}, int'(busy_a), 0);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   n;
    rst_n = 1'b1;
    ena_a = 1'b0;
    ena_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_duty", int'(duty_a), 0);
    check_val("rst_edges", int'(edges_a), 0);
    check_val("rst_valid", int'(valid_a), 0);
    check_val("rst_busy", int'(busy_a), 0);

    // One IDLE->ALIGN clock plus 32 ALIGN clocks before MEASURE on flat input
    run_a("low", 0, 0, 1'b0, 3, 0, 0, 33);
    run_a("high", 0, 0, 1'b1, 3, 32, 0, 33);
    run_a("sq4", 4, 2, 1'b0, 3, 16, 8, -1);
    run_a("p8", 8, 2, 1'b0, 3, 8, 4, -1);

    // Drop ena at window cycle 20 of the second window
    set_wave(4, 2, 1'b0);
    e.duty = 16;
    e.edges = 8;
    q_a.push_back(e);
    wait_busy_a("drop", lat);
    n = 0;
    while (!valid_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("drop_first_valid", int'(valid_a), 1);
    repeat (20) @(negedge clk);
    ena_a = 1'b0;
    @(negedge clk);
    check_val("drop_busy", int'(busy_a), 0);
    check_val("drop_duty_hold", int'(duty_a), 16);
    check_val("drop_edges_hold", int'(edges_a), 8);
    repeat (60) @(negedge clk);
    check_val("drop_duty_hold2", int'(duty_a), 16);
    check_val("drop_edges_hold2", int'(edges_a), 8);
    q_a.push_back(e);
    q_a.push_back(e);
    wait_busy_a("reen", lat);
    check_val("reen_realign", int'(lat >= 2), 1);
    drain_a("reen", 2 * 32 + 64);
    ena_a = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a window
    wait_busy_a("rstmid", lat);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_val("rstmid_duty", int'(duty_a), 0);
    check_val("rstmid_edges", int'(edges_a), 0);
    check_val("rstmid_valid", int'(valid_a), 0);
    check_val("rstmid_busy", int'(busy_a), 0);
    ena_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    run_a("post_rst", 8, 2, 1'b0, 1, 8, 4, -1);

    // 1024-clock window, toggling every 2 clocks: 256 rises saturate at 255
    set_wave(4, 2, 1'b0);
    e.duty = 512;
    e.edges = 255;
    q_b.push_back(e);
    q_b.push_back(e);
    ena_b = 1'b1;
    n = 0;
    while (q_b.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val("sat_drained", q_b.size(), 0);
    q_b.delete();
    ena_b = 1'b0;
    @(negedge clk);
    check_val("sat_busy_fall", int'(busy_b), 0);
    check_val("sat_edges_hold", int'(edges_b), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
